// File: rtl/fpa_pkg.sv
// Shared constants and types for the floating-point accumulator slice.
package fpa_pkg;

  localparam int unsigned DEF_EXP_WIDTH      = 8;
  localparam int unsigned DEF_MANTISSA_WIDTH = 23;
  localparam int unsigned FP_WIDTH           = 1 + DEF_EXP_WIDTH + DEF_MANTISSA_WIDTH;

  localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = '0;

  typedef enum logic [0:0] {
    ACCUM,
    HOLD
  } fpa_acc_state_t;

endpackage

// File: rtl/fp_adder.sv
// Combinational floating-point adder. Denormal inputs flush to zero and the
// result is truncated toward zero. The alignment frame is twice the
// significand width, so any sum that is exactly representable comes out exact.
// An exponent overflow returns signed infinity and an underflow returns +0.
module fp_adder #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23
) (
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] fpa_out,
  output logic                              overflow_out,
  output logic                              underflow_out
);

  localparam int unsigned FW   = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int unsigned SW   = MANTISSA_WIDTH + 1;
  localparam int unsigned SUMW = 2 * SW + 1;
  localparam int unsigned EMAX = (2 ** EXP_WIDTH) - 1;

  logic [FW-1:0]        big, sml;
  logic [EXP_WIDTH-1:0] big_exp, sml_exp, shift;
  logic [SW-1:0]        big_sig, sml_sig;
  logic [SUMW-1:0]      big_ext, sml_ext, sum, norm;
  int                   lead;
  int                   e_res;

  // Order operands by magnitude, align, add or subtract, then normalise.
  always_comb begin
    fpa_out       = '0;
    overflow_out  = 1'b0;
    underflow_out = 1'b0;
    lead          = 0;

    if (b_in[FW-2:0] > a_in[FW-2:0]) begin
      big = b_in;
      sml = a_in;
    end else begin
      big = a_in;
      sml = b_in;
    end
    big_exp = big[FW-2 -: EXP_WIDTH];
    sml_exp = sml[FW-2 -: EXP_WIDTH];
    big_sig = (big_exp == '0) ? '0 : {1'b1, big[MANTISSA_WIDTH-1:0]};
    sml_sig = (sml_exp == '0) ? '0 : {1'b1, sml[MANTISSA_WIDTH-1:0]};
    shift   = big_exp - sml_exp;

    big_ext = {1'b0, big_sig, {SW{1'b0}}};
    sml_ext = {1'b0, sml_sig, {SW{1'b0}}} >> shift;
    sum     = (big[FW-1] == sml[FW-1]) ? big_ext + sml_ext : big_ext - sml_ext;

    for (int i = 0; i < int'(SUMW); i++) begin
      if (sum[i]) lead = i;
    end
    norm  = sum << (int'(SUMW) - 1 - lead);
    // Unshifted big operand has its leading one at bit SUMW-2.
    e_res = int'(big_exp) + lead - (int'(SUMW) - 2);

    if (sum == '0) begin
      fpa_out = '0;
    end else if (e_res >= int'(EMAX)) begin
      overflow_out = 1'b1;
      fpa_out      = {big[FW-1], {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
    end else if (e_res <= 0) begin
      underflow_out = 1'b1;
      fpa_out       = '0;
    end else begin
      fpa_out = {big[FW-1], e_res[EXP_WIDTH-1:0], norm[SUMW-2 -: MANTISSA_WIDTH]};
    end
  end

endmodule

// File: rtl/fpa_accumulator.sv
// Streaming packet sum: folds each accepted beat into a running sum through
// one fp_adder and presents the sum, count and sticky flags on the last beat.
module fpa_accumulator
  import fpa_pkg::*;
#(
  parameter int unsigned EXP_WIDTH      = DEF_EXP_WIDTH,
  parameter int unsigned MANTISSA_WIDTH = DEF_MANTISSA_WIDTH,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] data_in,
  input  logic                              valid_in,
  input  logic                              last_in,
  output logic                              ready_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] sum_out,
  output logic                              sum_valid_out,
  input  logic                              sum_ready_in,
  output logic [COUNT_WIDTH-1:0]            count_out,
  output logic                              overflow_out,
  output logic                              underflow_out
);

  localparam int unsigned FW = 1 + EXP_WIDTH + MANTISSA_WIDTH;

  fpa_acc_state_t   state_q;
  logic [FW-1:0]    acc_q;
  logic [FW-1:0]    fpa_sum;
  logic             add_ovf, add_unf;
  logic [COUNT_WIDTH-1:0] count_q, count_inc;
  logic             sticky_ovf_q, sticky_unf_q;
  logic             beat_accept;

  fp_adder #(
    .EXP_WIDTH      (EXP_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH)
  ) fpa0 (
    .a_in          (acc_q),
    .b_in          (data_in),
    .fpa_out       (fpa_sum),
    .overflow_out  (add_ovf),
    .underflow_out (add_unf)
  );

  assign ready_out   = (state_q == ACCUM);
  assign beat_accept = valid_in && ready_out;
  assign count_inc   = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);

  // Accumulate beats in ACCUM, publish on last beat, wait for the consumer in HOLD.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ACCUM;
      acc_q         <= FW'(FP_POS_ZERO);
      count_q       <= '0;
      sticky_ovf_q  <= 1'b0;
      sticky_unf_q  <= 1'b0;
      sum_out       <= '0;
      sum_valid_out <= 1'b0;
      count_out     <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (beat_accept) begin
            if (last_in) begin
              sum_out       <= fpa_sum;
              count_out     <= count_inc;
              overflow_out  <= sticky_ovf_q | add_ovf;
              underflow_out <= sticky_unf_q | add_unf;
              sum_valid_out <= 1'b1;
              state_q       <= HOLD;
              acc_q         <= FW'(FP_POS_ZERO);
              count_q       <= '0;
              sticky_ovf_q  <= 1'b0;
              sticky_unf_q  <= 1'b0;
            end else begin
              acc_q        <= fpa_sum;
              count_q      <= count_inc;
              sticky_ovf_q <= sticky_ovf_q | add_ovf;
              sticky_unf_q <= sticky_unf_q | add_unf;
            end
          end
        end
        HOLD: begin
          if (sum_valid_out && sum_ready_in) begin
            sum_valid_out <= 1'b0;
            state_q       <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fpa_accumulator.sv
// Randomised and directed bench for fpa_accumulator. The reference sums packets
// as plain integers in 1/16 units and converts the result to single precision.
module tb_fpa_accumulator;
  import fpa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_in, valid_in, last_in, sum_ready_in;
  logic [31:0] data_in;

  logic        ready_a, sv_a, ovf_a, unf_a;
  logic [31:0] sum_a;
  logic [15:0] cnt_a;
  logic        ready_b, sv_b, ovf_b, unf_b;
  logic [31:0] sum_b;
  logic [1:0]  cnt_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fpa_accumulator #(.COUNT_WIDTH(16)) dut_a (
    .clk_in (clk), .rst_in (rst_in), .data_in (data_in), .valid_in (valid_in),
    .last_in (last_in), .ready_out (ready_a), .sum_out (sum_a), .sum_valid_out (sv_a),
    .sum_ready_in (sum_ready_in), .count_out (cnt_a), .overflow_out (ovf_a),
    .underflow_out (unf_a)
  );

  // Narrow counter instance shares the stimulus to exercise saturation.
  fpa_accumulator #(.COUNT_WIDTH(2)) dut_b (
    .clk_in (clk), .rst_in (rst_in), .data_in (data_in), .valid_in (valid_in),
    .last_in (last_in), .ready_out (ready_b), .sum_out (sum_b), .sum_valid_out (sv_b),
    .sum_ready_in (sum_ready_in), .count_out (cnt_b), .overflow_out (ovf_b),
    .underflow_out (unf_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-precision encoding of u/16; |u| must stay below 2^24.
  function automatic logic [31:0] to_fp(input int u);
    int          mag;
    int          m;
    logic [31:0] magb;
    if (u == 0) return 32'h0;
    mag = (u < 0) ? -u : u;
    m   = 0;
    for (int i = 0; i < 31; i++) if (mag[i]) m = i;
    magb = 32'(mag) << (23 - m);
    return {u < 0, 8'(127 + m - 4), magb[22:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int waited = 0;
    valid_in = 1'b1;
    data_in  = d;
    last_in  = l;
    while (!ready_a && waited < 50) begin
      tick();
      waited++;
    end
    if (!ready_a) check("ready_timeout", ready_a, 1);
    tick();
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  // Called right after the last beat; checks the result, then completes the handshake.
  task automatic collect(input string tag, input logic chk_sum, input logic [31:0] exp_sum,
                         input int exp_cnt, input int exp_cnt_b, input logic exp_ovf,
                         input logic exp_unf, input int delay);
    int waited = 0;
    sum_ready_in = 1'b0;
    while (!sv_a && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, sv_a, 1);
    check({tag, "_latency"}, waited, 0);
    check({tag, "_ready_low"}, ready_a, 0);
    if (chk_sum) begin
      check({tag, "_sum"}, sum_a, exp_sum);
      check({tag, "_sum_b"}, sum_b, exp_sum);
    end
    check({tag, "_count"}, cnt_a, exp_cnt);
    check({tag, "_count_sat"}, cnt_b, exp_cnt_b);
    check({tag, "_ovf"}, ovf_a, exp_ovf);
    check({tag, "_unf"}, unf_a, exp_unf);
    if (delay > 0) begin
      repeat (delay) tick();
      check({tag, "_hold_valid"}, sv_a, 1);
      check({tag, "_hold_count"}, cnt_a, exp_cnt);
      if (chk_sum) check({tag, "_hold_sum"}, sum_a, exp_sum);
    end
    sum_ready_in = 1'b1;
    tick();
    check({tag, "_release_valid"}, sv_a, 0);
    check({tag, "_release_ready"}, ready_a, 1);
  endtask

  initial begin
    int n, u, total;
    rst_in       = 1'b1;
    valid_in     = 1'b0;
    last_in      = 1'b0;
    data_in      = '0;
    sum_ready_in = 1'b0;
    repeat (2) tick();
    check("rst_ready", ready_a, 1);
    check("rst_valid", sv_a, 0);
    check("rst_sum", sum_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_flags", {ovf_a, unf_a}, 0);
    rst_in = 1'b0;
    tick();

    // Three-beat sum 1 + 2 + 0.5.
    sum_ready_in = 1'b1;
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'h40000000, 1'b0);
    send_beat(32'h3F000000, 1'b1);
    collect("three", 1'b1, 32'h40600000, 3, 3, 1'b0, 1'b0, 0);

    // Exact cancellation.
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'hBF800000, 1'b1);
    collect("cancel", 1'b1, 32'h00000000, 2, 2, 1'b0, 1'b0, 0);

    // Overflow is sticky within a packet and cleared for the next one.
    send_beat(32'h7F7FFFFF, 1'b0);
    send_beat(32'h7F7FFFFF, 1'b0);
    send_beat(32'h3F800000, 1'b1);
    collect("ovf", 1'b0, 32'h0, 3, 3, 1'b1, 1'b0, 0);
    send_beat(32'h40400000, 1'b1);
    collect("after_ovf", 1'b1, 32'h40400000, 1, 1, 1'b0, 1'b0, 0);

    // Underflow: 2^-126 - 1.5*2^-126 falls below the normal range.
    send_beat(32'h00800000, 1'b0);
    send_beat(32'h80C00000, 1'b1);
    collect("unf", 1'b0, 32'h0, 2, 2, 1'b0, 1'b1, 0);
    send_beat(32'h40400000, 1'b1);
    collect("after_unf", 1'b1, 32'h40400000, 1, 1, 1'b0, 1'b0, 0);

    // Backpressure with a beat waiting at the input.
    sum_ready_in = 1'b0;
    send_beat(32'h40000000, 1'b1);
    valid_in = 1'b1;
    data_in  = 32'h3F800000;
    last_in  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_ready", ready_a, 0);
      check("bp_sum", sum_a, 32'h40000000);
      check("bp_valid", sv_a, 1);
      tick();
    end
    sum_ready_in = 1'b1;
    tick();
    check("bp_ready_back", ready_a, 1);
    check("bp_valid_drop", sv_a, 0);
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'h3F800000, 1'b1);
    collect("bp_next", 1'b1, 32'h40000000, 2, 2, 1'b0, 1'b0, 0);

    // Counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) send_beat(32'h3F800000, i == 4);
    collect("sat", 1'b1, 32'h40A00000, 5, 3, 1'b0, 1'b0, 0);

    // Reset mid-packet discards the partial sum.
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'h3F800000, 1'b0);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("midrst_valid", sv_a, 0);
    check("midrst_ready", ready_a, 1);
    tick();
    check("midrst_valid2", sv_a, 0);
    send_beat(32'h40000000, 1'b1);
    collect("midrst", 1'b1, 32'h40000000, 1, 1, 1'b0, 1'b0, 0);

    // Random packets of multiples of 1/16, all partial sums exactly representable.
    for (int p = 0; p < 40; p++) begin
      n     = int'($urandom_range(1, 8));
      total = 0;
      for (int b = 0; b < n; b++) begin
        u     = int'($urandom_range(0, 131070)) - 65535;
        total += u;
        repeat ($urandom_range(0, 1)) tick();
        send_beat(to_fp(u), b == n - 1);
      end
      collect("rand", 1'b1, to_fp(total), n, (n > 3) ? 3 : n, 1'b0, 1'b0,
              int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpa_accumulator.md
Name: fpa_accumulator

Overview:
Sequential streaming reduction stage that sits directly downstream of fp_adder and wraps one instance of it. It accepts a packet of floating-point operands over a valid/ready handshake and feeds the registered running sum back into the adder. On the last beat it presents the packet sum, element count and sticky overflow/underflow flags over an output valid/ready handshake. It is the first clocked block in floating_point_adder and turns the combinational adder into a reusable dot-product/sum engine.

Parameters:
EXP_WIDTH, 8, exponent field width; passed through to fp_adder.
MANTISSA_WIDTH, 23, mantissa field width; passed through to fp_adder.
COUNT_WIDTH, 16, width of the per-packet element counter.

Ports:
clk_in  input  1  single clock; all state updates on rising edge.
rst_in  input  1  synchronous, active-high reset.
data_in  input  1+EXP_WIDTH+MANTISSA_WIDTH  operand beat (sign|exp|mantissa).
valid_in  input  1  data_in/last_in valid.
last_in  input  1  beat is final element of the packet.
ready_out  output  1  block can accept a beat this cycle.
sum_out  output  1+EXP_WIDTH+MANTISSA_WIDTH  packet sum.
sum_valid_out  output  1  sum_out/count_out/flags valid.
sum_ready_in  input  1  consumer accepts the sum.
count_out  output  COUNT_WIDTH  beats in the presented packet, saturating.
overflow_out  output  1  sticky: any add in the packet overflowed.
underflow_out  output  1  sticky: any add in the packet underflowed.

Behaviour:
- Reset is synchronous and active-high on rst_in; clock is clk_in.
- Reset state: ACCUM. acc = +0.0 (all zeros), count = 0, sticky flags = 0. Outputs: sum_out = 0, sum_valid_out = 0, count_out = 0, overflow_out = 0, underflow_out = 0. ready_out is 1 in the first cycle after reset.
- The fp_adder instance is combinational, with a_in = acc register and b_in = data_in. There are no other adders.
- FSM states: ACCUM and HOLD.
- ACCUM:
  - ready_out = 1.
  - Beat accepted when valid_in && ready_out.
  - On an accepted beat with last_in = 0: acc <= fpa_out. count <= count+1, saturating at all-ones. sticky_ovf |= overflow_out(adder). sticky_unf |= underflow_out(adder).
  - On an accepted beat with last_in = 1:
    - sum_out <= fpa_out. count_out <= sat(count+1). overflow_out/underflow_out <= sticky OR current adder flags.
    - sum_valid_out <= 1. Go to HOLD.
    - acc <= +0.0, count <= 0, sticky flags <= 0.
  - valid_in = 0: no state change.
- HOLD:
  - ready_out = 0. valid_in is ignored and the beat is not consumed.
  - sum_out, count_out and the flags are held stable while sum_valid_out = 1.
  - When sum_valid_out && sum_ready_in: sum_valid_out <= 0 and go to ACCUM, so ready_out = 1 in the next cycle.
  - The output registers keep their last value after the handshake; only sum_valid_out qualifies them.
- Latency: sum_valid_out rises on the clock edge that accepts the last beat, i.e. it is visible 1 cycle after the last-beat handshake.
- Minimum packet period: N beat cycles + 1 handshake cycle when sum_ready_in is held high.
- Single-beat packet (last_in on the first beat): sum = 0.0 + x = x, count_out = 1.
- Zero-length packets cannot occur, because last_in always travels with a beat.
- Flags are those reported by fp_adder. No NaN/Inf special handling is done here; an overflowed acc keeps accumulating whatever fpa_out returns.
- Reset mid-packet or in HOLD discards the partial sum and any pending result. No output valid is produced for that packet.
- The ready_out/sum_valid_out rules are fixed: ready_out depends only on state, and sum_valid_out never depends combinationally on sum_ready_in.

Decomposition:
- Package fpa_pkg holds:
  - EXP_WIDTH and MANTISSA_WIDTH defaults, and the derived FP_WIDTH = 1+EXP_WIDTH+MANTISSA_WIDTH.
  - Constant FP_POS_ZERO.
  - Enum typedef fpa_acc_state_t {ACCUM, HOLD}.
- fpa_tb_pkg imports fpa_pkg.
- One sub-module: the existing fp_adder, instantiated as fpa0. All other logic is inline.

Test Plan:
1. Three-beat sum: beats 0x3F800000, 0x40000000, 0x3F000000+last with sum_ready_in = 1 -> one cycle after the last beat, sum_valid_out = 1, sum_out = 0x40600000 (3.5), count_out = 3, flags 0.
2. Cancellation: 0x3F800000, then 0xBF800000+last -> sum_out = 0x00000000, count_out = 2, overflow_out = 0, underflow_out = 0.
3. Overflow stickiness: 0x7F7FFFFF, 0x7F7FFFFF, then 0x3F800000+last -> overflow_out = 1 at the output and cleared for the next packet. Next packet 0x40400000+last -> sum_out = 0x40400000, overflow_out = 0.
4. Backpressure: finish packet {0x40000000+last} with sum_ready_in = 0 for 4 cycles while valid_in = 1 -> ready_out = 0 and sum_out stable at 0x40000000 throughout. After sum_ready_in = 1, ready_out returns to 1 the following cycle, and the held beat is then accepted as the first element of the next packet.
5. Counter saturation (COUNT_WIDTH = 2): 5 beats of 0x3F800000, last on beat 5 -> count_out = 3, sum_out = 0x40A00000.
6. Reset mid-packet: 2 beats of 0x3F800000, then rst_in high for 1 cycle, then 0x40000000+last -> sum_out = 0x40000000, count_out = 1, and no sum_valid_out for the aborted packet.
